// File: rtl/midi_message_parser_if.sv
// Byte stream from the MIDI byte reader into the channel-voice parser.
interface midi_message_parser_if;
   logic       byte_valid;
   logic [7:0] byte_data;

   modport master (output byte_valid, output byte_data);
   modport slave  (input  byte_valid, input  byte_data);
endinterface

// File: rtl/midi_message_parser.sv
// MIDI channel-voice parser: running status, channel mask, SysEx/real-time skipping,
// held-note map with incremental held-note count.
module midi_message_parser #(
   parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
   parameter logic [6:0]  MOD_CC       = 7'd1,
   parameter logic [6:0]  ALLOFF_CC    = 7'd123
) (
   input  logic                  clk,
   input  logic                  rst,
   midi_message_parser_if.slave  byte_if,
   output logic                  note_on_evt_o,
   output logic                  note_off_evt_o,
   output logic [3:0]            evt_channel_o,
   output logic [6:0]            evt_note_o,
   output logic [6:0]            evt_velocity_o,
   output logic [6:0]            mod_value_o,
   output logic [13:0]           pitch_bend_o,
   output logic                  all_off_evt_o,
   output logic [127:0]          note_map_o,
   output logic [7:0]            held_count_o
);

   typedef enum logic [1:0] {StNoStatus, StWaitD1, StWaitD2, StSysex} state_e;

   state_e       state_q, state_d;
   logic [7:0]   status_q, status_d;
   logic [6:0]   d1_q, d1_d;
   logic         complete;
   logic [6:0]   data;

   logic         note_on_q, note_on_d;
   logic         note_off_q, note_off_d;
   logic         all_off_q, all_off_d;
   logic [3:0]   channel_q, channel_d;
   logic [6:0]   note_q, note_d;
   logic [6:0]   velocity_q, velocity_d;
   logic [6:0]   mod_q, mod_d;
   logic [13:0]  bend_q, bend_d;
   logic [127:0] map_q, map_d;
   logic [7:0]   count_q, count_d;

   assign data = byte_if.byte_data[6:0];

   // Parser: real-time bytes (F8..FF) fall through without touching anything.
   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      d1_d     = d1_q;
      complete = 1'b0;
      if (byte_if.byte_valid && byte_if.byte_data < 8'hF8) begin
         if (byte_if.byte_data[7]) begin
            if (byte_if.byte_data < 8'hF0) begin
               status_d = byte_if.byte_data;
               state_d  = StWaitD1;
            end else begin
               status_d = 8'h00;
               state_d  = (byte_if.byte_data == 8'hF0) ? StSysex : StNoStatus;
            end
         end else begin
            case (state_q)
               StWaitD1: begin
                  d1_d = data;
                  // Cx/Dx carry one data byte and have no output effect.
                  state_d = (status_q[7:5] == 3'b110) ? StWaitD1 : StWaitD2;
               end
               StWaitD2: begin
                  complete = 1'b1;
                  state_d  = StWaitD1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      note_on_d  = 1'b0;
      note_off_d = 1'b0;
      all_off_d  = 1'b0;
      channel_d  = channel_q;
      note_d     = note_q;
      velocity_d = velocity_q;
      mod_d      = mod_q;
      bend_d     = bend_q;
      map_d      = map_q;
      count_d    = count_q;
      if (complete && CHANNEL_MASK[status_q[3:0]]) begin
         case (status_q[7:4])
            4'h8, 4'h9: begin
               channel_d  = status_q[3:0];
               note_d     = d1_q;
               velocity_d = data;
               if (status_q[4] && data != 7'd0) begin
                  note_on_d   = 1'b1;
                  map_d[d1_q] = 1'b1;
                  if (!map_q[d1_q]) count_d = count_q + 8'd1;
               end else begin
                  note_off_d  = 1'b1;
                  map_d[d1_q] = 1'b0;
                  if (map_q[d1_q]) count_d = count_q - 8'd1;
               end
            end
            4'hB: begin
               if (d1_q == MOD_CC) mod_d = data;
               if (d1_q == ALLOFF_CC) begin
                  map_d     = '0;
                  count_d   = 8'd0;
                  all_off_d = 1'b1;
               end
            end
            4'hE: bend_d = {data, d1_q};
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StNoStatus;
         status_q   <= 8'h00;
         d1_q       <= 7'd0;
         note_on_q  <= 1'b0;
         note_off_q <= 1'b0;
         all_off_q  <= 1'b0;
         channel_q  <= 4'd0;
         note_q     <= 7'd0;
         velocity_q <= 7'd0;
         mod_q      <= 7'd0;
         bend_q     <= 14'h2000;
         map_q      <= '0;
         count_q    <= 8'd0;
      end else begin
         state_q    <= state_d;
         status_q   <= status_d;
         d1_q       <= d1_d;
         note_on_q  <= note_on_d;
         note_off_q <= note_off_d;
         all_off_q  <= all_off_d;
         channel_q  <= channel_d;
         note_q     <= note_d;
         velocity_q <= velocity_d;
         mod_q      <= mod_d;
         bend_q     <= bend_d;
         map_q      <= map_d;
         count_q    <= count_d;
      end
   end

   assign note_on_evt_o  = note_on_q;
   assign note_off_evt_o = note_off_q;
   assign all_off_evt_o  = all_off_q;
   assign evt_channel_o  = channel_q;
   assign evt_note_o     = note_q;
   assign evt_velocity_o = velocity_q;
   assign mod_value_o    = mod_q;
   assign pitch_bend_o   = bend_q;
   assign note_map_o     = map_q;
   assign held_count_o   = count_q;

endmodule

// File: tb/tb_midi_message_parser.sv
// Bench for midi_message_parser: two instances (all channels / channel 0 only) fed one stream.
module tb_midi_message_parser;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   midi_message_parser_if bus_a ();
   midi_message_parser_if bus_b ();

   logic         on_o  [2];
   logic         off_o [2];
   logic         all_o [2];
   logic [3:0]   ch_o  [2];
   logic [6:0]   note_o[2];
   logic [6:0]   vel_o [2];
   logic [6:0]   mod_o [2];
   logic [13:0]  pb_o  [2];
   logic [127:0] map_o [2];
   logic [7:0]   cnt_o [2];

   midi_message_parser #(.CHANNEL_MASK(16'hFFFF)) dut_a (
      .clk(clk), .rst(rst), .byte_if(bus_a.slave),
      .note_on_evt_o(on_o[0]), .note_off_evt_o(off_o[0]), .evt_channel_o(ch_o[0]),
      .evt_note_o(note_o[0]), .evt_velocity_o(vel_o[0]), .mod_value_o(mod_o[0]),
      .pitch_bend_o(pb_o[0]), .all_off_evt_o(all_o[0]), .note_map_o(map_o[0]),
      .held_count_o(cnt_o[0])
   );

   midi_message_parser #(.CHANNEL_MASK(16'h0001)) dut_b (
      .clk(clk), .rst(rst), .byte_if(bus_b.slave),
      .note_on_evt_o(on_o[1]), .note_off_evt_o(off_o[1]), .evt_channel_o(ch_o[1]),
      .evt_note_o(note_o[1]), .evt_velocity_o(vel_o[1]), .mod_value_o(mod_o[1]),
      .pitch_bend_o(pb_o[1]), .all_off_evt_o(all_o[1]), .note_map_o(map_o[1]),
      .held_count_o(cnt_o[1])
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Cycles each pulse was seen high, per instance.
   int on_cnt[2]  = '{0, 0};
   int off_cnt[2] = '{0, 0};
   int all_cnt[2] = '{0, 0};
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (on_o[k])  on_cnt[k]++;
         if (off_o[k]) off_cnt[k]++;
         if (all_o[k]) all_cnt[k]++;
      end
   end

   // Reference model: message = status + however many data bytes that status needs.
   logic [7:0]   m_status;
   logic [6:0]   m_data[$];
   logic [127:0] m_map[2];
   logic [6:0]   m_mod[2], m_note[2], m_vel[2];
   logic [13:0]  m_pb[2];
   logic [3:0]   m_ch[2];
   logic         m_on[2], m_off[2], m_all[2];

   task automatic model_reset();
      m_status = 8'h00;
      m_data.delete();
      for (int k = 0; k < 2; k++) begin
         m_map[k] = '0;  m_mod[k] = 0;  m_note[k] = 0;  m_vel[k] = 0;
         m_pb[k] = 14'h2000;  m_ch[k] = 0;
         m_on[k] = 0;  m_off[k] = 0;  m_all[k] = 0;
      end
   endtask

   task automatic model_apply(input logic [7:0] st, input logic [6:0] d1, input logic [6:0] d2);
      logic [15:0] mask;
      for (int k = 0; k < 2; k++) begin
         mask = (k == 0) ? 16'hFFFF : 16'h0001;
         if (mask[st[3:0]]) begin
            case (st[7:4])
               4'h8, 4'h9: begin
                  m_ch[k] = st[3:0];  m_note[k] = d1;  m_vel[k] = d2;
                  if (st[7:4] == 4'h9 && d2 != 0) begin m_map[k][d1] = 1'b1; m_on[k] = 1; end
                  else begin m_map[k][d1] = 1'b0; m_off[k] = 1; end
               end
               4'hB: begin
                  if (d1 == 7'd1) m_mod[k] = d2;
                  if (d1 == 7'd123) begin m_map[k] = '0; m_all[k] = 1; end
               end
               4'hE: m_pb[k] = {d2, d1};
               default: ;
            endcase
         end
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      int need;
      for (int k = 0; k < 2; k++) begin m_on[k] = 0; m_off[k] = 0; m_all[k] = 0; end
      if (b >= 8'hF8) return;
      if (b[7]) begin
         m_status = (b < 8'hF0) ? b : 8'h00;
         m_data.delete();
      end else if (m_status != 8'h00) begin
         m_data.push_back(b[6:0]);
         need = (m_status[7:4] == 4'hC || m_status[7:4] == 4'hD) ? 1 : 2;
         if (m_data.size() == need) begin
            model_apply(m_status, m_data[0], (need == 2) ? m_data[1] : 7'd0);
            m_data.delete();
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus_a.byte_valid = 1'b1;  bus_a.byte_data = b;
      bus_b.byte_valid = 1'b1;  bus_b.byte_data = b;
      @(posedge clk); #1;
      bus_a.byte_valid = 1'b0;  bus_b.byte_valid = 1'b0;
      model_byte(b);
   endtask

   task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
      send_byte(a); send_byte(b); send_byte(c);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      idle(2);
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++; if (on_o[0] !== 1'b0 || off_o[0] !== 1'b0 || all_o[0] !== 1'b0) begin
         n_fail++; $display("FAIL reset_pulses: got %b%b%b want 000", on_o[0], off_o[0], all_o[0]);
      end
      n_cmp++; if ({ch_o[0], note_o[0], vel_o[0], mod_o[0]} !== 25'd0) begin
         n_fail++; $display("FAIL reset_evt: got ch %h note %h vel %h mod %h want 0",
                            ch_o[0], note_o[0], vel_o[0], mod_o[0]);
      end
      n_cmp++; if (pb_o[0] !== 14'h2000) begin
         n_fail++; $display("FAIL reset_bend: got %h want 2000", pb_o[0]);
      end
      n_cmp++; if (map_o[0] !== 128'd0 || cnt_o[0] !== 8'd0) begin
         n_fail++; $display("FAIL reset_map: got map %h count %0d want 0", map_o[0], cnt_o[0]);
      end
   endtask

   task automatic test_note_on();
      int on0;
      do_reset();
      on0 = on_cnt[0];
      send3(8'h90, 8'h3C, 8'h64);
      n_cmp++; if (on_o[0] !== 1'b1) begin
         n_fail++; $display("FAIL note_on_latency: got %b want 1", on_o[0]);
      end
      idle(3);
      n_cmp++; if (on_cnt[0] - on0 != 1) begin
         n_fail++; $display("FAIL note_on_width: got %0d cycles want 1", on_cnt[0] - on0);
      end
      n_cmp++; if (note_o[0] !== 7'h3C || vel_o[0] !== 7'h64) begin
         n_fail++; $display("FAIL note_on_evt: got note %h vel %h want 3c 64", note_o[0], vel_o[0]);
      end
      n_cmp++; if (map_o[0] !== (128'd1 << 60) || cnt_o[0] !== 8'd1) begin
         n_fail++; $display("FAIL note_on_map: got map %h count %0d want bit60 1", map_o[0], cnt_o[0]);
      end
   endtask

   task automatic test_running_status();
      int on0, off0;
      do_reset();
      on0 = on_cnt[0];  off0 = off_cnt[0];
      send3(8'h90, 8'h3C, 8'h64);
      send_byte(8'h40); send_byte(8'h50); send_byte(8'h3C); send_byte(8'h00);
      idle(2);
      n_cmp++; if (on_cnt[0] - on0 != 2 || off_cnt[0] - off0 != 1) begin
         n_fail++; $display("FAIL running_pulses: got on %0d off %0d want 2 1",
                            on_cnt[0] - on0, off_cnt[0] - off0);
      end
      n_cmp++; if (map_o[0] !== (128'd1 << 64) || cnt_o[0] !== 8'd1) begin
         n_fail++; $display("FAIL running_map: got map %h count %0d want bit64 1", map_o[0], cnt_o[0]);
      end
      n_cmp++; if (vel_o[0] !== 7'd0) begin
         n_fail++; $display("FAIL running_vel0: got %h want 0", vel_o[0]);
      end
   endtask

   task automatic test_realtime();
      int on0;
      do_reset();
      on0 = on_cnt[0];
      send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'hF8); send_byte(8'h64);
      idle(2);
      n_cmp++; if (on_cnt[0] - on0 != 1 || note_o[0] !== 7'h3C || map_o[0] !== (128'd1 << 60)) begin
         n_fail++; $display("FAIL realtime: got on %0d note %h map %h want 1 3c bit60",
                            on_cnt[0] - on0, note_o[0], map_o[0]);
      end
   endtask

   task automatic test_channel_mask();
      int on1;
      do_reset();
      on1 = on_cnt[1];
      send3(8'h91, 8'h3C, 8'h64);
      idle(2);
      n_cmp++; if (on_cnt[1] != on1 || map_o[1] !== 128'd0) begin
         n_fail++; $display("FAIL mask_reject: got on %0d map %h want 0 0", on_cnt[1] - on1, map_o[1]);
      end
      n_cmp++; if (cnt_o[0] !== 8'd1 || ch_o[0] !== 4'd1) begin
         n_fail++; $display("FAIL mask_all_accept: got count %0d ch %0d want 1 1", cnt_o[0], ch_o[0]);
      end
      send3(8'h90, 8'h3C, 8'h64);
      idle(2);
      n_cmp++; if (on_cnt[1] - on1 != 1 || cnt_o[1] !== 8'd1) begin
         n_fail++; $display("FAIL mask_accept: got on %0d count %0d want 1 1", on_cnt[1] - on1, cnt_o[1]);
      end
   endtask

   task automatic test_cc_bend();
      do_reset();
      send3(8'hB0, 8'h01, 8'h55);
      n_cmp++; if (mod_o[0] !== 7'h55) begin
         n_fail++; $display("FAIL mod_value: got %h want 55", mod_o[0]);
      end
      send3(8'hE0, 8'h12, 8'h34);
      n_cmp++; if (pb_o[0] !== 14'h1A12) begin
         n_fail++; $display("FAIL bend_mid: got %h want 1a12", pb_o[0]);
      end
      send3(8'hE0, 8'h00, 8'h40);
      n_cmp++; if (pb_o[0] !== 14'h2000) begin
         n_fail++; $display("FAIL bend_center: got %h want 2000", pb_o[0]);
      end
      send3(8'hE0, 8'h7F, 8'h7F);
      n_cmp++; if (pb_o[0] !== 14'h3FFF) begin
         n_fail++; $display("FAIL bend_max: got %h want 3fff", pb_o[0]);
      end
   endtask

   task automatic test_all_off();
      int all0, off0;
      do_reset();
      send3(8'h90, 8'h3C, 8'h64);
      send_byte(8'h3E); send_byte(8'h64); send_byte(8'h40); send_byte(8'h64);
      n_cmp++; if (cnt_o[0] !== 8'd3) begin
         n_fail++; $display("FAIL alloff_setup: got count %0d want 3", cnt_o[0]);
      end
      all0 = all_cnt[0];  off0 = off_cnt[0];
      send3(8'hB0, 8'h7B, 8'h00);
      idle(2);
      n_cmp++; if (all_cnt[0] - all0 != 1 || off_cnt[0] != off0) begin
         n_fail++; $display("FAIL alloff_pulses: got all %0d off %0d want 1 0",
                            all_cnt[0] - all0, off_cnt[0] - off0);
      end
      n_cmp++; if (map_o[0] !== 128'd0 || cnt_o[0] !== 8'd0) begin
         n_fail++; $display("FAIL alloff_map: got map %h count %0d want 0", map_o[0], cnt_o[0]);
      end
   endtask

   task automatic test_sysex();
      int on0, off0;
      do_reset();
      on0 = on_cnt[0];  off0 = off_cnt[0];
      send3(8'hF0, 8'h3C, 8'h64);
      send3(8'hF7, 8'h3C, 8'h64);
      idle(2);
      n_cmp++; if (on_cnt[0] != on0 || off_cnt[0] != off0 || map_o[0] !== 128'd0) begin
         n_fail++; $display("FAIL sysex: got on %0d off %0d map %h want 0 0 0",
                            on_cnt[0] - on0, off_cnt[0] - off0, map_o[0]);
      end
   endtask

   task automatic test_reset_mid();
      int on0;
      do_reset();
      on0 = on_cnt[0];
      send_byte(8'h90); send_byte(8'h3C);
      #2 rst = 1'b1;
      model_reset();
      #5 rst = 1'b0;
      idle(1);
      send_byte(8'h64);
      idle(2);
      n_cmp++; if (on_cnt[0] != on0 || note_o[0] !== 7'd0 || cnt_o[0] !== 8'd0) begin
         n_fail++; $display("FAIL reset_mid: got on %0d note %h count %0d want 0 0 0",
                            on_cnt[0] - on0, note_o[0], cnt_o[0]);
      end
      n_cmp++; if (pb_o[0] !== 14'h2000 || map_o[0] !== 128'd0) begin
         n_fail++; $display("FAIL reset_mid_vals: got pb %h map %h want 2000 0", pb_o[0], map_o[0]);
      end
   endtask

   task automatic test_back_to_back();
      int on0, off0;
      do_reset();
      on0 = on_cnt[0];  off0 = off_cnt[0];
      send3(8'h90, 8'h3C, 8'h64);
      send3(8'h90, 8'h3C, 8'h64);
      idle(1);
      n_cmp++; if (cnt_o[0] !== 8'd1 || on_cnt[0] - on0 != 2) begin
         n_fail++; $display("FAIL dup_on: got count %0d on %0d want 1 2", cnt_o[0], on_cnt[0] - on0);
      end
      send3(8'h80, 8'h3C, 8'h40);
      send3(8'h80, 8'h3C, 8'h40);
      idle(1);
      n_cmp++; if (cnt_o[0] !== 8'd0 || off_cnt[0] - off0 != 2 || vel_o[0] !== 7'h40) begin
         n_fail++; $display("FAIL dup_off: got count %0d off %0d vel %h want 0 2 40",
                            cnt_o[0], off_cnt[0] - off0, vel_o[0]);
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      logic [3:0] hi;
      int r;
      logic [3:0] his[9] = '{4'h8, 4'h9, 4'h9, 4'h9, 4'hB, 4'hE, 4'hC, 4'hA, 4'hD};
      do_reset();
      for (int i = 0; i < 600; i++) begin
         r = $urandom_range(0, 99);
         if (r < 14) begin
            hi = his[$urandom_range(0, 8)];
            b = {hi, 4'($urandom_range(0, 2))};
         end else if (r < 17) b = 8'hF8 + 8'($urandom_range(0, 7));
         else if (r < 19) b = 8'hF0;
         else if (r < 20) b = 8'hF1 + 8'($urandom_range(0, 6));
         else begin
            r = $urandom_range(0, 9);
            if (r < 2) b = 8'h00;
            else if (r == 2) b = 8'h7B;
            else if (r == 3) b = 8'h01;
            else b = 8'h3C + 8'($urandom_range(0, 7));
         end
         send_byte(b);
         for (int k = 0; k < 2; k++) begin
            n_cmp++; if ({on_o[k], off_o[k], all_o[k]} !== {m_on[k], m_off[k], m_all[k]}) begin
               n_fail++; $display("FAIL rnd_pulses[%0d] byte %0d (%h): got %b%b%b want %b%b%b", k, i, b,
                                  on_o[k], off_o[k], all_o[k], m_on[k], m_off[k], m_all[k]);
            end
            n_cmp++; if ({ch_o[k], note_o[k], vel_o[k]} !== {m_ch[k], m_note[k], m_vel[k]}) begin
               n_fail++; $display("FAIL rnd_evt[%0d] byte %0d: got %h/%h/%h want %h/%h/%h", k, i,
                                  ch_o[k], note_o[k], vel_o[k], m_ch[k], m_note[k], m_vel[k]);
            end
            n_cmp++; if (mod_o[k] !== m_mod[k] || pb_o[k] !== m_pb[k]) begin
               n_fail++; $display("FAIL rnd_ctrl[%0d] byte %0d: got mod %h pb %h want %h %h", k, i,
                                  mod_o[k], pb_o[k], m_mod[k], m_pb[k]);
            end
            n_cmp++; if (map_o[k] !== m_map[k]) begin
               n_fail++; $display("FAIL rnd_map[%0d] byte %0d: got %h want %h", k, i, map_o[k], m_map[k]);
            end
            n_cmp++; if (cnt_o[k] !== 8'($countones(m_map[k]))) begin
               n_fail++; $display("FAIL rnd_count[%0d] byte %0d: got %0d want %0d", k, i,
                                  cnt_o[k], $countones(m_map[k]));
            end
         end
         idle($urandom_range(0, 2));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bus_a.byte_valid = 1'b0;  bus_a.byte_data = 8'h00;
      bus_b.byte_valid = 1'b0;  bus_b.byte_data = 8'h00;
      model_reset();
      test_reset();
      test_note_on();
      test_running_status();
      test_realtime();
      test_channel_mask();
      test_cc_bend();
      test_all_off();
      test_sysex();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
